// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions for the hazard scoreboard: source-slot names and the
// forwarding-select encoding for "read from register file".
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    RS1 = 2'd0,
    RS2 = 2'd1,
    RS3 = 2'd2
  } src_slot_e;

  localparam int NSRC   = 3;
  localparam int FWD_RF = 0;

endpackage

// File: rtl/wb_match.sv
// Priority match of one register query {fp, idx} against all writeback ports;
// returns k+1 for the lowest matching port k, FWD_RF when nothing matches.
module wb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NWB  = 2
) (
  input  logic                           fp,
  input  logic [$clog2(NREG)-1:0]        idx,
  input  logic [NWB-1:0]                 wb_valid,
  input  logic [NWB-1:0]                 wb_fp,
  input  logic [NWB*$clog2(NREG)-1:0]    wb_rd,
  output logic [$clog2(NWB+1)-1:0]       sel
);

  localparam int RW = $clog2(NREG);
  localparam int FW = $clog2(NWB + 1);

  // Scan from the highest port down so the lowest matching port is left in sel.
  always_comb begin
    sel = FW'(FWD_RF);
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wb_valid[k] && (wb_fp[k] == fp) && (wb_rd[k*RW +: RW] == idx) &&
          (fp || (idx != '0))) begin
        sel = FW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks pending writers per {fp, idx}, raises a
// combinational stall on RAW/WAW/capacity hazards and selects WB forwarding.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NWB      = 2,
  parameter int MAX_INFL = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             iss_valid,
  input  logic                             iss_wr,
  input  logic                             iss_fp,
  input  logic [$clog2(NREG)-1:0]          iss_rd,
  input  logic [2:0]                       src_use,
  input  logic [2:0]                       src_fp,
  input  logic [3*$clog2(NREG)-1:0]        src_idx,
  input  logic [NWB-1:0]                   wb_valid,
  input  logic [NWB-1:0]                   wb_fp,
  input  logic [NWB*$clog2(NREG)-1:0]      wb_rd,
  input  logic                             flush,
  output logic                             stall,
  output logic [3*$clog2(NWB+1)-1:0]       fwd_sel,
  output logic [$clog2(MAX_INFL+1)-1:0]    inflight
);

  localparam int RW = $clog2(NREG);
  localparam int FW = $clog2(NWB + 1);
  localparam int CW = $clog2(MAX_INFL + 1);
  localparam int NE = 2 * NREG;

  logic [NE-1:0]   pending;
  logic [FW-1:0]   src_sel [NSRC];
  logic [FW-1:0]   rd_sel;
  logic [NSRC-1:0] src_haz;
  logic [NE-1:0]   clr_vec, clr_eff, set_vec;
  logic [RW:0]     iss_ix;
  logic            rd_hit, waw, commit, inc;
  logic [CW-1:0]   infl_nxt;
  int              n_clr;

  function automatic logic [CW-1:0] sat_cnt(input int cur, input int up, input int dn);
    int t;
    t = cur + up - dn;
    if (t < 0) return '0;
    if (t > MAX_INFL) return CW'(MAX_INFL);
    return CW'(t);
  endfunction

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    wb_match #(.NREG(NREG), .NWB(NWB)) u_src_match (
      .fp       (src_fp[s]),
      .idx      (src_idx[s*RW +: RW]),
      .wb_valid (wb_valid),
      .wb_fp    (wb_fp),
      .wb_rd    (wb_rd),
      .sel      (src_sel[s])
    );
    assign fwd_sel[s*FW +: FW] = src_sel[s];
  end

  wb_match #(.NREG(NREG), .NWB(NWB)) u_rd_match (
    .fp       (iss_fp),
    .idx      (iss_rd),
    .wb_valid (wb_valid),
    .wb_fp    (wb_fp),
    .wb_rd    (wb_rd),
    .sel      (rd_sel)
  );

  assign iss_ix = {iss_fp, iss_rd};
  assign rd_hit = (rd_sel != FW'(FWD_RF));

  // Hazard detection; a same-cycle writeback to the entry resolves the hazard.
  always_comb begin
    src_haz = '0;
    for (int s = 0; s < NSRC; s++) begin
      src_haz[s] = src_use[s] & pending[{src_fp[s], src_idx[s*RW +: RW]}] &
                   (src_sel[s] == FW'(FWD_RF));
    end
  end

  // Duplicate ports land on the same bit, so they count as a single clear.
  always_comb begin
    clr_vec = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid[k]) begin
        clr_vec[{wb_fp[k], wb_rd[k*RW +: RW]}] =
          clr_vec[{wb_fp[k], wb_rd[k*RW +: RW]}] | pending[{wb_fp[k], wb_rd[k*RW +: RW]}];
      end
    end
  end

  assign waw    = iss_wr & pending[iss_ix] & ~rd_hit;
  assign stall  = iss_valid & ((|src_haz) | waw |
                  (iss_wr & (inflight == CW'(MAX_INFL)) & ~(|clr_vec)));
  assign commit = iss_valid & iss_wr & ~stall & ~flush & (iss_fp | (iss_rd != '0));

  // Set wins over a same-entry clear: the entry stays pending and neither counts.
  always_comb begin
    set_vec = '0;
    if (commit) set_vec[iss_ix] = 1'b1;
    clr_eff = clr_vec & ~set_vec;
    inc     = commit & ~clr_vec[iss_ix];
    n_clr   = 0;
    for (int i = 0; i < NE; i++) begin
      n_clr = n_clr + int'(clr_eff[i]);
    end
    infl_nxt = sat_cnt(int'(inflight), int'(inc), n_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      inflight <= '0;
    end else if (flush) begin
      pending  <= '0;
      inflight <= '0;
    end else begin
      pending  <= (pending & ~clr_eff) | set_vec;
      inflight <= infl_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a behavioural reference model
// feeds an expectation queue that is drained against the DUT every cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG     = 32;
  localparam int NWB      = 2;
  localparam int MAX_INFL = 4;
  localparam int RW       = $clog2(NREG);
  localparam int FW       = $clog2(NWB + 1);
  localparam int CW       = $clog2(MAX_INFL + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  iss_valid, iss_wr, iss_fp;
  logic [RW-1:0]         iss_rd;
  logic [2:0]            src_use, src_fp;
  logic [3*RW-1:0]       src_idx;
  logic [NWB-1:0]        wb_valid, wb_fp;
  logic [NWB*RW-1:0]     wb_rd;
  logic                  flush;
  logic                  stall;
  logic [3*FW-1:0]       fwd_sel;
  logic [CW-1:0]         inflight;

  typedef struct {
    logic            stall;
    logic [3*FW-1:0] fwd;
    int              infl;
    string           tag;
  } exp_t;

  exp_t sbq[$];
  bit   pend [2][NREG];
  int   infl;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_scoreboard #(.NREG(NREG), .NWB(NWB), .MAX_INFL(MAX_INFL)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_fp    (iss_fp),
    .iss_rd    (iss_rd),
    .src_use   (src_use),
    .src_fp    (src_fp),
    .src_idx   (src_idx),
    .wb_valid  (wb_valid),
    .wb_fp     (wb_fp),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .stall     (stall),
    .fwd_sel   (fwd_sel),
    .inflight  (inflight)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0; iss_fp = 0; iss_rd = '0;
    src_use = '0; src_fp = '0; src_idx = '0;
    wb_valid = '0; wb_fp = '0; wb_rd = '0; flush = 0;
  endtask

  task automatic set_iss(input bit fp, input int rd);
    iss_valid = 1; iss_wr = 1; iss_fp = fp; iss_rd = RW'(rd);
  endtask

  task automatic set_src(input int s, input bit fp, input int idx);
    src_use[s] = 1; src_fp[s] = fp; src_idx[s*RW +: RW] = RW'(idx);
  endtask

  task automatic set_wb(input int k, input bit fp, input int rd);
    wb_valid[k] = 1; wb_fp[k] = fp; wb_rd[k*RW +: RW] = RW'(rd);
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++) pend[f][r] = 0;
    infl = 0;
  endtask

  function automatic int port_match(input bit fp, input int idx);
    int sel = 0;
    if (!fp && idx == 0) return 0;
    for (int k = 0; k < NWB; k++) begin
      if (sel == 0 && wb_valid[k] && wb_fp[k] == fp && int'(wb_rd[k*RW +: RW]) == idx)
        sel = k + 1;
    end
    return sel;
  endfunction

  function automatic exp_t model_out(input string tag);
    exp_t e;
    bit   haz = 0, anyclr = 0, waw;
    int   sel, idx;
    e.tag = tag;
    e.fwd = '0;
    for (int s = 0; s < 3; s++) begin
      idx = int'(src_idx[s*RW +: RW]);
      sel = port_match(src_fp[s], idx);
      e.fwd[s*FW +: FW] = FW'(sel);
      if (src_use[s] && pend[src_fp[s]][idx] && sel == 0) haz = 1;
    end
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k] && pend[wb_fp[k]][int'(wb_rd[k*RW +: RW])]) anyclr = 1;
    waw = iss_wr && pend[iss_fp][int'(iss_rd)] && port_match(iss_fp, int'(iss_rd)) == 0;
    e.stall = iss_valid && (haz || waw || (iss_wr && infl == MAX_INFL && !anyclr));
    e.infl  = infl;
    return e;
  endfunction

  task automatic model_update(input bit st);
    bit clr [2][NREG];
    bit commit;
    if (flush) begin
      model_reset();
      return;
    end
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++) clr[f][r] = 0;
    for (int k = 0; k < NWB; k++)
      if (wb_valid[k] && pend[wb_fp[k]][int'(wb_rd[k*RW +: RW])])
        clr[wb_fp[k]][int'(wb_rd[k*RW +: RW])] = 1;
    commit = iss_valid && iss_wr && !st && !(iss_fp == 0 && iss_rd == '0);
    if (commit) begin
      if (clr[iss_fp][int'(iss_rd)]) clr[iss_fp][int'(iss_rd)] = 0;
      else infl++;
      pend[iss_fp][int'(iss_rd)] = 1;
    end
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++)
        if (clr[f][r]) begin
          pend[f][r] = 0;
          infl--;
        end
    if (infl < 0) infl = 0;
    if (infl > MAX_INFL) infl = MAX_INFL;
  endtask

  // Inputs are already driven (just after a negedge); check, then advance one cycle.
  task automatic step(input string tag);
    exp_t e, o;
    e = model_out(tag);
    sbq.push_back(e);
    #2;
    o = sbq.pop_front();
    chk_val({o.tag, ".stall"}, int'(stall), int'(o.stall));
    chk_val({o.tag, ".fwd"}, int'(fwd_sel), int'(o.fwd));
    chk_val({o.tag, ".infl"}, int'(inflight), o.infl);
    model_update(o.stall);
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1;
    #12;
    chk_val("rst.infl", int'(inflight), 0);
    chk_val("rst.stall", int'(stall), 0);
    set_src(int'(RS2), 0, 9);
    set_wb(0, 0, 9);
    #1;
    chk_val("rst.fwd", int'(fwd_sel), 1 << FW);
    idle();
    @(negedge clk);
    rst = 0;

    // RAW on int rd 5, resolved by forwarding from WB port 0
    set_iss(0, 5);                                 step("raw.issue");
    set_src(int'(RS1), 0, 5);                      step("raw.stall");
    set_src(int'(RS1), 0, 5); set_wb(0, 0, 5);     step("raw.fwd");
    set_src(int'(RS1), 0, 5);                      step("raw.cleared");

    // integer x0 never becomes pending
    set_iss(0, 0);                                 step("x0.issue");
    set_src(int'(RS2), 0, 0); set_wb(1, 0, 0);     step("x0.use");

    // FP and integer files are distinct
    set_iss(1, 3);                                 step("fp.issue");
    set_src(int'(RS1), 0, 3); set_wb(0, 0, 3);     step("fp.int_src");
    set_src(int'(RS3), 1, 3);                      step("fp.fp_src");
    set_src(int'(RS3), 1, 3); set_wb(0, 1, 3); set_wb(1, 1, 3); step("fp.fwd_prio");

    // WAW on a pending destination
    set_iss(0, 8);                                 step("waw.issue");
    set_iss(0, 8);                                 step("waw.stall");
    set_wb(1, 0, 8);                               step("waw.clear");

    // capacity limit
    for (int r = 10; r < 14; r++) begin
      set_iss(0, r);                               step("cap.fill");
    end
    set_iss(0, 14);                                step("cap.full");
    set_iss(0, 14); set_wb(0, 0, 10);              step("cap.swap");
    set_wb(0, 0, 11); set_wb(1, 0, 11);            step("cap.dup_wb");
    set_src(int'(RS2), 0, 12); set_wb(1, 0, 12);   step("cap.fwd_p1");
    set_wb(0, 0, 13); set_wb(1, 0, 14);            step("cap.drain");
    set_src(int'(RS1), 0, 14);                     step("cap.empty");

    // same-cycle clear and re-issue of rd 7
    set_iss(0, 7);                                 step("setwin.issue");
    set_iss(0, 7); set_wb(0, 0, 7);                step("setwin.both");
    set_src(int'(RS1), 0, 7);                      step("setwin.still");
    set_wb(0, 0, 7);                               step("setwin.clear");

    // flush with a simultaneous valid issue
    set_iss(0, 20);                                step("flush.w0");
    set_iss(0, 21);                                step("flush.w1");
    set_iss(1, 22);                                step("flush.w2");
    set_iss(0, 23); flush = 1;                     step("flush.cycle");
    set_src(int'(RS1), 0, 20); set_src(int'(RS2), 0, 21); set_src(int'(RS3), 1, 22);
    set_iss(0, 23);                                step("flush.after");
    set_wb(0, 0, 23);                              step("flush.cleanup");

    // asynchronous reset mid-operation
    set_iss(0, 2);                                 step("arst.issue");
    set_iss(0, 4);
    #1;
    rst = 1;
    #1;
    chk_val("arst.infl", int'(inflight), 0);
    idle();
    model_reset();
    @(negedge clk);
    rst = 0;
    set_src(int'(RS1), 0, 2);                      step("arst.probe");

    // randomised traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr    = 1'($urandom_range(0, 1));
      iss_fp    = 1'($urandom_range(0, 1));
      iss_rd    = RW'($urandom_range(0, 5));
      src_use   = 3'($urandom_range(0, 7));
      src_fp    = 3'($urandom_range(0, 7));
      for (int s = 0; s < 3; s++) src_idx[s*RW +: RW] = RW'($urandom_range(0, 5));
      for (int k = 0; k < NWB; k++) begin
        wb_valid[k] = 1'($urandom_range(0, 2) == 0);
        wb_fp[k]    = 1'($urandom_range(0, 1));
        wb_rd[k*RW +: RW] = RW'($urandom_range(0, 5));
      end
      flush = ($urandom_range(0, 29) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
